tns_decoder_21_pipe: RTL

TNS_DECODER_21_PIPE -- requirements
Module: tns_decoder_21_pipe

---
 rtl/tns_decoder_21_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/tns_decoder_21_pipe.sv
// TNS 21-bit decoder: weighted bit sum in two registered stages.
// Ports: clock/rst_n, codein+in_valid/in_ready, dataout+err_out+out_valid/out_ready.
`ifndef TNS_HDR_SVH
`define TNS_HDR_SVH
`define BLEN07 14
`define TNS1_A 2
`define TNS1_B 1
`define TNS1_C 1
`define TNS2_A 8
`define TNS2_B 4
`define TNS2_C 4
`define TNS3_A 32
`define TNS3_B 16
`define TNS3_C 16
`define TNS4_A 128
`define TNS4_B 64
`define TNS4_C 64
`define TNS5_A 512
`define TNS5_B 256
`define TNS5_C 256
`define TNS6_A 2048
`define TNS6_B 1024
`define TNS6_C 1024
`define TNS7_A 8192
`define TNS7_B 4096
`define TNS7_C 4096
`endif

module tns_decoder_21_pipe #(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [20:0]        codein,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [`BLEN07-1:0] dataout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_out
);

  localparam int W = `BLEN07 + 1;
  typedef logic [W-1:0] sum_t;

  function automatic sum_t grp(
    input logic [2:0] g,
    input int         a,
    input int         b,
    input int         c
  );
    sum_t s;
    s = '0;
    if (g[2]) s = s + sum_t'(a);
    if (g[1]) s = s + sum_t'(b);
    if (g[0]) s = s + sum_t'(c);
    return s;
  endfunction

  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;
  sum_t p_hi;
  sum_t p_lo;
  sum_t p_hi_d;
  sum_t p_lo_d;
  sum_t sum;

  // Group 1 low bit (bit 0) carries unit weight, added separately.
  always_comb begin
    p_hi_d = grp(codein[20:18], `TNS7_A, `TNS7_B, `TNS7_C)
           + grp(codein[17:15], `TNS6_A, `TNS6_B, `TNS6_C)
           + grp(codein[14:12], `TNS5_A, `TNS5_B, `TNS5_C)
           + grp(codein[11:9],  `TNS4_A, `TNS4_B, `TNS4_C);
    p_lo_d = grp(codein[8:6], `TNS3_A, `TNS3_B, `TNS3_C)
           + grp(codein[5:3], `TNS2_A, `TNS2_B, `TNS2_C)
           + grp({codein[2:1], 1'b0}, `TNS1_A, `TNS1_B, `TNS1_C)
           + sum_t'(codein[0]);
  end

  assign sum       = p_hi + p_lo;
  assign out_valid = s2_valid;
  // Depends only on stage valids and out_ready, never on in_valid.
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid && (!s2_valid || out_ready);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      p_hi     <= '0;
      p_lo     <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      p_hi     <= p_hi_d;
      p_lo     <= p_lo_d;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      dataout  <= '0;
      err_out  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      dataout  <= sum[W-2:0];
      err_out  <= CHECK_EN && sum[W-1];
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule
